// File: rtl/amba_axi_write_arbiter_if.sv
// Bus bundle shared by the AXI write arbiter and the logic around it.
// Requester side : req_valid/req_addr/req_data in, req_ready/req_done/req_err out.
// Engine side    : aacaddr/aacdata with aacaddrvalid/aacdatavalid strobes.
// Monitored AXI  : wvalid/wready, bvalid/bready, bresp.
// Status         : busy, grant_id, hung.
// master modport is the arbiter's view; slave modport is the surrounding logic's view.
interface amba_axi_write_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    localparam int unsigned IW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*32-1:0] req_addr;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_done;
    logic [NREQ-1:0]    req_err;

    logic [31:0]        aacaddr;
    logic [31:0]        aacdata;
    logic               aacaddrvalid;
    logic               aacdatavalid;

    logic               wvalid;
    logic               wready;
    logic               bvalid;
    logic               bready;
    logic [1:0]         bresp;

    logic               busy;
    logic [IW-1:0]      grant_id;
    logic               hung;

    modport master (
        input  req_valid, req_addr, req_data,
        input  wvalid, wready, bvalid, bready, bresp,
        output req_ready, req_done, req_err,
        output aacaddr, aacdata, aacaddrvalid, aacdatavalid,
        output busy, grant_id, hung
    );

    modport slave (
        output req_valid, req_addr, req_data,
        output wvalid, wready, bvalid, bready, bresp,
        input  req_ready, req_done, req_err,
        input  aacaddr, aacdata, aacaddrvalid, aacdatavalid,
        input  busy, grant_id, hung
    );
endinterface

// File: rtl/amba_axi_write_arbiter.sv
// Round-robin arbiter sharing the single-beat AXI write engine between NREQ
// requesters. One transaction outstanding at a time; a watchdog parks the
// arbiter in HUNG if the B handshake does not arrive within TIMEOUT cycles.
// Ports:
//   aclk   - clock
//   areset - synchronous active-high reset
//   bus    - amba_axi_write_arbiter_if.master (requesters, engine strobes,
//            monitored W/B handshakes, busy/grant_id/hung status)
module amba_axi_write_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     aclk,
    input  logic                     areset,
    amba_axi_write_arbiter_if.master bus
);
    localparam int unsigned IW  = $clog2(NREQ);
    localparam int unsigned WDW = 16;
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);
    localparam logic [WDW-1:0] WD_MAX   = '1;
    localparam logic [IW-1:0]  LAST_RST = IW'(NREQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DATA,
        S_RESP,
        S_HUNG
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] ready_q, ready_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] err_q, err_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic            addrvalid_q, addrvalid_d;
    logic            datavalid_q, datavalid_d;
    logic            busy_q, busy_d;
    logic            hung_q, hung_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   last_q, last_d;
    logic [WDW-1:0]  wd_q, wd_d;

    logic            pick_found_c;
    logic [IW-1:0]   pick_idx_c;
    logic [WDW-1:0]  wd_inc_c;
    logic            w_hs_c;
    logic            b_hs_c;

    logic [31:0]     req_addr_a [NREQ];
    logic [31:0]     req_data_a [NREQ];

    // Unpack the flat requester buses into per-requester words.
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign req_addr_a[i] = bus.req_addr[32*i +: 32];
        assign req_data_a[i] = bus.req_data[32*i +: 32];
    end

    assign w_hs_c   = bus.wvalid && bus.wready;
    assign b_hs_c   = bus.bvalid && bus.bready;
    assign wd_inc_c = (wd_q == WD_MAX) ? wd_q : wd_q + WDW'(1);

    // Round-robin search from last+1 upward, wrapping without a modulo so
    // non-power-of-two NREQ works.
    always_comb begin : rr_pick
        int unsigned idx;
        pick_found_c = 1'b0;
        pick_idx_c   = '0;
        idx          = 0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = 32'(last_q) + off;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!pick_found_c && bus.req_valid[IW'(idx)]) begin
                pick_found_c = 1'b1;
                pick_idx_c   = IW'(idx);
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        ready_d     = '0;
        done_d      = '0;
        err_d       = '0;
        addr_d      = addr_q;
        data_d      = data_q;
        addrvalid_d = 1'b0;
        datavalid_d = 1'b0;
        hung_d      = hung_q;
        grant_d     = grant_q;
        last_d      = last_q;
        wd_d        = wd_q;

        unique case (state_q)
            S_IDLE: begin
                if (pick_found_c) begin
                    state_d             = S_ISSUE;
                    addr_d              = req_addr_a[pick_idx_c];
                    data_d              = req_data_a[pick_idx_c];
                    ready_d[pick_idx_c] = 1'b1;
                    grant_d             = pick_idx_c;
                    last_d              = pick_idx_c;
                    wd_d                = '0;
                    addrvalid_d         = 1'b1;
                    datavalid_d         = 1'b1;
                end
            end
            S_ISSUE, S_DATA: begin
                wd_d = wd_inc_c;
                if (wd_q == WD_LIMIT) begin
                    state_d = S_HUNG;
                    hung_d  = 1'b1;
                end else if (w_hs_c) begin
                    state_d = S_RESP;
                end else begin
                    state_d     = S_DATA;
                    datavalid_d = 1'b1;
                end
            end
            S_RESP: begin
                wd_d = wd_inc_c;
                // Completion takes priority over a simultaneous watchdog expiry.
                if (b_hs_c) begin
                    state_d         = S_IDLE;
                    done_d[grant_q] = 1'b1;
                    err_d[grant_q]  = (bus.bresp != 2'b00);
                end else if (wd_q == WD_LIMIT) begin
                    state_d = S_HUNG;
                    hung_d  = 1'b1;
                end
            end
            S_HUNG: begin
                hung_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= S_IDLE;
            ready_q     <= '0;
            done_q      <= '0;
            err_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            addrvalid_q <= 1'b0;
            datavalid_q <= 1'b0;
            busy_q      <= 1'b0;
            hung_q      <= 1'b0;
            grant_q     <= '0;
            last_q      <= LAST_RST;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            addrvalid_q <= addrvalid_d;
            datavalid_q <= datavalid_d;
            busy_q      <= busy_d;
            hung_q      <= hung_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            wd_q        <= wd_d;
        end
    end

    assign bus.req_ready    = ready_q;
    assign bus.req_done     = done_q;
    assign bus.req_err      = err_q;
    assign bus.aacaddr      = addr_q;
    assign bus.aacdata      = data_q;
    assign bus.aacaddrvalid = addrvalid_q;
    assign bus.aacdatavalid = datavalid_q;
    assign bus.busy         = busy_q;
    assign bus.hung         = hung_q;
    assign bus.grant_id     = grant_q;
endmodule
